// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule definitions:
//   - width constants for the C/D halves, PC1 output, subkey and key
//   - PC1 index table and the pc1() helper that applies it
//   - one-shift round mask (bit r-1 set => round r rotates by 1, else by 2)
//   - key-schedule FSM state enum
// Bit numbering: DES bit 1 is the MSB of every vector.
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 56;
    localparam int KEY_W    = 64;

    // Rounds 1, 2, 9 and 16 rotate by one position, every other round by two.
    localparam logic [15:0] ONE_SHIFT_MASK = 16'b1000_0001_0000_0011;

    typedef enum logic {IDLE, EMIT} state_t;

    // PC1 output bit i+1 takes key bit PC1_TAB[i] (both 1-based, DES order).
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Parity bits (8, 16, ..., 64) never appear in PC1_TAB, so they drop out here.
    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W - PC1_TAB[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_subkey_gen_pc2.sv
// -----------------------------------------------------------------------------
// des_subkey_gen_pc2
// DES permuted choice 2: selects 48 of the 56 C/D bits to form a round subkey.
// Purely combinational.
// Ports:
//   cd      in  56  {C,D}; cd[55] = input bit 1
//   subkey  out 48  subkey[47] = output bit 1
// -----------------------------------------------------------------------------
module des_subkey_gen_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    localparam int PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    always_comb begin
        subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            subkey[SUBKEY_W-1-i] = cd[CD_W - PC2_TAB[i]];
        end
    end

endmodule

// File: rtl/des_subkey_gen.sv
// -----------------------------------------------------------------------------
// des_subkey_gen
// Sequential DES key schedule. Expands a 64-bit key into K1..K16, one subkey
// per valid/ready handshake, in forward order (encrypt) or reverse order
// (decrypt). Reverse order is produced by rotating C/D right, so no subkey
// storage is needed.
// Ports:
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset
//   start         in   1   load key and begin a schedule (only while idle)
//   decrypt       in   1   sampled with start: 0 = K1..K16, 1 = K16..K1
//   key           in  64   DES key, key[63] = DES bit 1, parity ignored
//   busy          out  1   schedule in progress
//   subkey_valid  out  1   subkey/round_idx hold a valid subkey
//   subkey_ready  in   1   consumer accepts subkey on valid & ready
//   subkey        out 48   PC2(C,D), subkey[47] = PC2 bit 1
//   round_idx     out  4   round of current subkey, 0..15 = K1..K16
//   done          out  1   one-cycle pulse after the 16th accepted subkey
// -----------------------------------------------------------------------------
module des_subkey_gen
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        done
);

    state_t        state, state_nxt;
    logic [27:0]   c_q, d_q, c_nxt, d_nxt;
    logic [3:0]    idx_nxt;
    logic          dec_q, dec_nxt, done_nxt;
    logic [55:0]   pc1_key;
    logic          last, shift_one;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    assign pc1_key = pc1(key);

    assign last = dec_q ? (round_idx == 4'd0) : (round_idx == 4'd15);

    // Encrypt rotates into round (round_idx+2, 1-based) => mask bit round_idx+1.
    // Decrypt undoes the rotation of the round just delivered => mask bit round_idx.
    // The encrypt index wraps only on the last round, where no rotation happens.
    assign shift_one = dec_q ? ONE_SHIFT_MASK[round_idx]
                             : ONE_SHIFT_MASK[round_idx + 4'd1];

    assign busy         = (state == EMIT);
    assign subkey_valid = (state == EMIT);

    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        d_nxt     = d_q;
        idx_nxt   = round_idx;
        dec_nxt   = dec_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    dec_nxt   = decrypt;
                    state_nxt = EMIT;
                    if (decrypt) begin
                        // C0/D0 equals C16/D16, so K16 needs no rotation.
                        c_nxt   = pc1_key[55:28];
                        d_nxt   = pc1_key[27:0];
                        idx_nxt = 4'd15;
                    end else begin
                        c_nxt   = rotl(pc1_key[55:28], 1'b1);
                        d_nxt   = rotl(pc1_key[27:0], 1'b1);
                        idx_nxt = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (last) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (dec_q) begin
                        c_nxt   = rotr(c_q, shift_one);
                        d_nxt   = rotr(d_q, shift_one);
                        idx_nxt = round_idx - 4'd1;
                    end else begin
                        c_nxt   = rotl(c_q, shift_one);
                        d_nxt   = rotl(d_q, shift_one);
                        idx_nxt = round_idx + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            round_idx <= '0;
            dec_q     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            c_q       <= c_nxt;
            d_q       <= d_nxt;
            round_idx <= idx_nxt;
            dec_q     <= dec_nxt;
            done      <= done_nxt;
        end
    end

    des_subkey_gen_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

endmodule

// File: doc/des_subkey_gen.md
# des_subkey_gen

Sequential DES key-schedule engine that expands a 64-bit key into the 16 round subkeys K1..K16, one per handshake. Subkeys come out in forward order (K1→K16) for encryption or reverse order (K16→K1) for decryption. For decryption it rotates C/D right instead of left, so no subkey storage is needed. It sits between the key register and the round datapath, and drives the existing PC2 permutation from its C/D registers.

## Interface
- No parameters; all widths are fixed by DES.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load the key and begin a schedule; accepted only while busy=0.
- decrypt  in  1  sampled with start: 0 = forward order, 1 = reverse order.
- key  in  64  DES key; key[63] = DES bit 1; parity bits 8,16,…,64 are ignored.
- busy  out  1  high from the cycle after an accepted start until done.
- subkey_valid  out  1  subkey/round_idx hold a valid subkey.
- subkey_ready  in  1  consumer accepts the subkey when valid&ready.
- subkey  out  48  current subkey; subkey[47] = PC2 output bit 1.
- round_idx  out  4  DES round of the current subkey, 0..15 = K1..K16.
- done  out  1  one-cycle pulse after the 16th accepted subkey.

## Operation
- States: IDLE, EMIT.
- IDLE: on start, C/D ← PC1(key).
  - Encrypt: C/D are additionally rotated left by 1, giving C1/D1; round_idx←0.
  - Decrypt: C/D are not rotated, since C0/D0 equals C16/D16; round_idx←15.
  - Latch decrypt and go to EMIT.
- EMIT:
  - subkey = PC2(C,D), taken combinationally from the registers.
  - subkey_valid=1.
  - On valid&ready with fewer than 16 accepted, advance to the next subkey.
- Shift counts:
  - Encrypt: rotate C and D left by s(r) for the next round r; s=1 for rounds 1, 2, 9, 16, otherwise 2.
  - Decrypt: rotate right by s(round_idx+1) of the subkey just delivered, giving the sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C and D are each 28 bits and rotate independently; rotation is modulo 28.
- Counter: round_idx increments (encrypt) or decrements (decrypt); it never wraps during a schedule.
- 16th handshake: state→IDLE, subkey_valid←0, done←1 for one cycle, busy←0. C/D keep their values; subkey is don't-care while valid=0.
- start while busy: ignored. start in the same cycle as the final handshake: ignored (block is still busy). start in the cycle done is high: accepted.
- decrypt and key changes while busy: no effect.
- ready held low: subkey, round_idx and valid are held stable indefinitely.
- Reset values:
  - State IDLE.
  - C=D=0, so subkey = 48'h0.
  - round_idx=0, subkey_valid=0, busy=0, done=0.
- Reset mid-schedule aborts at once; no done pulse is produced.

## Timing
- start accepted at edge T → at T+1: subkey_valid=1, busy=1, first subkey on the outputs.
- Handshake at edge N → next subkey valid at N+1, so with ready tied high there is one subkey per cycle.
- ready tied high: subkeys at T+1..T+16, done at T+17 with busy=0.
- done coincides with the first IDLE cycle; the earliest restart is start sampled in that cycle.
- No combinational path from start/key to any output.
- subkey depends only on registers, through PC2.
- subkey_valid is registered and does not depend on ready.

## Structure
- Shared package des_pkg holds:
  - PC1 index table (56 entries);
  - 16-bit one-shift round mask 16'b1000_0001_0000_0011 (bit r-1 set ⇒ shift 1);
  - state enum {IDLE, EMIT};
  - width constants (28, 48, 56, 64).
- One sub-module: the existing PC2 block, fed {C,D} as its 1..56 input.
- PC1 and the rotations are inline.
- Expected size: ~150–250 lines.

## Test plan
- Encrypt, key 64'h133457799BBCDFF1, ready=1: K1=48'h1B02EFFC7072 at T+1 (round_idx 0), K2=48'h79AED9DBC9E5 at T+2, K16=48'hCB3D8B0E17F5 at T+16; done pulse at T+17.
- Decrypt, same key: round_idx 15 with 48'hCB3D8B0E17F5 at T+1, then 48'h79AED9DBC9E5 at round_idx 1, 48'h1B02EFFC7072 at T+16. Bench checks all 16 values equal the encrypt run reversed.
- Backpressure: ready toggles randomly and held low 5 cycles at round_idx 8. subkey and round_idx stay stable; exactly 16 handshakes occur, then one done pulse.
- Start while busy (different key, decrypt=1) at round 4: ignored, original sequence unchanged. Start in the done cycle: new schedule begins the next cycle.
- rst asserted during round 10: next cycle valid=0, busy=0, subkey=0, no done. A fresh start afterwards produces the correct K1.
- Key 64'h0000000000000000 and 64'hFEFEFEFEFEFEFEFE, in both directions: all subkeys 48'h0 for the first and 48'hFFFFFFFFFFFF for the second, confirming parity bits are ignored.
